// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch slice of the MIPS pipeline.
package fetch_stage_pkg;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] word_t;
   typedef logic [7:0]  i8;

   // Request side of the instruction bus: valid/addr held until addr_ok.
   typedef struct packed {
      logic  valid;
      addr_t addr;
   } ibus_req_t;

   // Response side: addr_ok accepts the request, data_ok returns the word.
   typedef struct packed {
      logic  addr_ok;
      logic  data_ok;
      word_t data;
   } ibus_resp_t;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} fetch_state_t;

   localparam addr_t       RESET_PC_DEFAULT = 32'hBFC0_0000;
   localparam int unsigned EV_ADEL          = 1;

   // Word fetches require the two low address bits to be zero.
   function automatic logic isAligned(input addr_t pc);
      return (pc[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/fetch_stage_pc_select.sv
// Next-PC selection for the fetch stage plus the pending-branch register that
// carries a taken branch across the delay-slot fetch.
module pc_select
   import fetch_stage_pkg::*;
(
   input  logic  clk,
   input  logic  resetn,
   input  logic  PCSrcD,
   input  addr_t PCBranchD,
   input  logic  ex_or_eret,
   input  addr_t RedirectPC,
   input  addr_t PCPlus4F,
   input  logic  advance,
   output addr_t nextPc,
   output logic  brPend
);

   addr_t brTgt;

   // Remember a taken branch until the delay slot has been fetched and the PC advances.
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!resetn) begin
         brPend <= 1'b0;
         brTgt  <= '0;
      end else if (ex_or_eret) begin
         brPend <= 1'b0;
      end else if (advance) begin
         brPend <= 1'b0;
      end else if (PCSrcD) begin
         brPend <= 1'b1;
         brTgt  <= PCBranchD;
      end
   end

   // Priority mux: redirect beats branch, branch beats sequential; a branch
   // resolving on the very advance cycle is taken without waiting for the latch.
   always_comb begin
      // NOTE: assigning a default first keeps this block free of inferred latches.
      nextPc = PCPlus4F;
      if (ex_or_eret)  nextPc = RedirectPC;
      else if (PCSrcD) nextPc = PCBranchD;
      else if (brPend) nextPc = brTgt;
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, runs the ibus handshake, buffers the returned word
// across stalls and applies branch / exception redirects.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter addr_t       RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned ADEL_BIT = EV_ADEL
) (
   input  logic       clk,
   input  logic       resetn,
   output ibus_req_t  ireq,
   input  ibus_resp_t iresp,
   input  logic       StallF,
   input  logic       PCSrcD,
   input  addr_t      PCBranchD,
   input  logic       ex_or_eret,
   input  addr_t      RedirectPC,
   output addr_t      PCF,
   output addr_t      PCPlus4F,
   output word_t      InstrF,
   output logic       i_data_ok,
   output i8          EVectorF,
   output logic       IStallF
);

   fetch_state_t state, stateNext;
   addr_t        pcReg, storedPc, nextPc;
   word_t        ibuf;
   logic         adel, discard, brPend;
   logic         beatDone, dropBeat, advance;

   assign PCF      = pcReg;
   assign PCPlus4F = pcReg + 32'd4;

   // A data beat lands either together with addr_ok or later while waiting.
   assign beatDone = (((state == REQ) && iresp.addr_ok) || (state == WAIT)) && iresp.data_ok;
   // A beat belonging to a flushed fetch is thrown away instead of delivered.
   assign dropBeat = discard || ex_or_eret;
   assign advance  = (state == DONE) && !StallF;

   pc_select u_pc_select (
      .clk        (clk),
      .resetn     (resetn),
      .PCSrcD     (PCSrcD),
      .PCBranchD  (PCBranchD),
      .ex_or_eret (ex_or_eret),
      .RedirectPC (RedirectPC),
      .PCPlus4F   (PCPlus4F),
      .advance    (advance),
      .nextPc     (nextPc),
      .brPend     (brPend)
   );

   // Fetch FSM state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= stateNext;
   end

   // Next-state logic for the ibus handshake.
   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE: begin
            if (ex_or_eret)              stateNext = IDLE;
            else if (isAligned(pcReg))   stateNext = REQ;
            else                         stateNext = DONE;
         end
         REQ: begin
            if (iresp.addr_ok) begin
               if (!iresp.data_ok)       stateNext = WAIT;
               else                      stateNext = dropBeat ? IDLE : DONE;
            end
         end
         WAIT: begin
            if (iresp.data_ok)           stateNext = dropBeat ? IDLE : DONE;
         end
         DONE: begin
            if (ex_or_eret)              stateNext = IDLE;
            else if (!StallF)            stateNext = isAligned(nextPc) ? REQ : IDLE;
         end
         default:                        stateNext = IDLE;
      endcase
   end

   // PC, instruction buffer, AdEL flag and the discard/redirect bookkeeping.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pcReg    <= RESET_PC;
         ibuf     <= '0;
         adel     <= 1'b0;
         discard  <= 1'b0;
         storedPc <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (ex_or_eret) pcReg <= nextPc;
               else            adel  <= !isAligned(pcReg);
            end
            REQ, WAIT: begin
               if (beatDone && dropBeat) begin
                  pcReg   <= ex_or_eret ? RedirectPC : storedPc;
                  discard <= 1'b0;
               end else if (beatDone) begin
                  ibuf <= iresp.data;
               end else if (ex_or_eret) begin
                  discard  <= 1'b1;
                  storedPc <= RedirectPC;
               end
            end
            DONE: begin
               if (ex_or_eret || !StallF) begin
                  pcReg <= nextPc;
                  adel  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign ireq      = '{valid: (state == REQ), addr: pcReg};
   assign i_data_ok = (state == DONE) && !discard;
   assign IStallF   = !i_data_ok;
   assign InstrF    = (i_data_ok && !adel) ? ibuf : '0;

   // Only the AdEL bit of the exception vector is ever driven by fetch.
   always_comb begin
      EVectorF           = '0;
      EVectorF[ADEL_BIT] = i_data_ok && adel;
   end

endmodule
